bitstream_window: RTL and testbench

- Upstream feeder for the bit-peek stage. Accepts the raw NAL byte stream from the DDR fetch FIFO over a valid/ready handshake.
- Strips H.264 emulation-prevention bytes (0x00 0x00 0x03 → 0x00 0x00).
- Maintains an MSB-aligned 24-bit window whose bit 23 is the next unread bit; the peek and Exp-Golomb stages read this window.
- Consumers advance the read position by up to 24 bits per cycle.

---
 rtl/h264_bs_pkg.sv | 9 +
 rtl/bitstream_window_if.sv | 11 +
 rtl/bs_epb_filter.sv | 32 +++
 rtl/bitstream_window.sv | 90 +++++++++
 tb/tb_bitstream_window.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/h264_bs_pkg.sv
// rtl/h264_bs_pkg.sv - shared constants and types for the H.264 bitstream front end
package h264_bs_pkg;

    localparam logic [7:0] EPB_BYTE = 8'h03;
    localparam int         MAX_FWD  = 24;

    typedef logic [6:0] bit_count_t;

endpackage

// File: rtl/bitstream_window_if.sv
// rtl/bitstream_window_if.sv - byte-stream handshake into the bitstream window
interface bitstream_window_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/bs_epb_filter.sv
// rtl/bs_epb_filter.sv - zero-run tracker deciding which 0x03 bytes are emulation prevention
module bs_epb_filter
    import h264_bs_pkg::*;
#(
    parameter bit EPB_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       accept,
    input  logic       flush,
    output logic       drop
);

    logic [1:0] zero_run;

    assign drop = EPB_EN && (zero_run == 2'd2) && (byte_in == EPB_BYTE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            zero_run <= 2'd0;
        end else if (accept) begin
            // a dropped 0x03 breaks the run, so 00 00 03 03 keeps the second 03
            if (drop || byte_in != 8'h00) begin
                zero_run <= 2'd0;
            end else if (zero_run != 2'd2) begin
                zero_run <= zero_run + 2'd1;
            end
        end
    end

endmodule

// File: rtl/bitstream_window.sv
// rtl/bitstream_window.sv - EPB-stripping byte buffer exposing an MSB-aligned 24-bit peek window
module bitstream_window
    import h264_bs_pkg::*;
#(
    parameter int BUF_W  = 64,
    parameter bit EPB_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    bitstream_window_if.slave bs,
    input  logic             flush,
    input  logic [4:0]       forward_len,
    output logic [23:0]      window,
    output logic             window_valid,
    output logic [6:0]       bits_avail,
    output logic             byte_aligned,
    output logic [CNT_W-1:0] consumed_bits,
    output logic             err_underflow
);

    logic [BUF_W-1:0] buffer;
    bit_count_t       bit_count;
    logic [CNT_W-1:0] consumed_q;
    logic             err_q;

    logic             accept;
    logic             drop;
    logic             fwd_ok;
    bit_count_t       consume;
    bit_count_t       remain;
    logic [BUF_W-1:0] insert;
    logic [BUF_W-1:0] buffer_nx;
    bit_count_t       count_nx;

    // Space for two more bytes guarantees an accept with no consume cannot overflow.
    assign bs.byte_ready = !rst && !flush && (bit_count <= bit_count_t'(BUF_W - 16));
    assign accept        = bs.byte_valid && bs.byte_ready;

    assign fwd_ok  = ({2'b00, forward_len} <= bit_count) && (forward_len <= 5'(MAX_FWD));
    assign consume = fwd_ok ? {2'b00, forward_len} : '0;
    assign remain  = bit_count - consume;

    bs_epb_filter #(
        .EPB_EN (EPB_EN)
    ) u_epb (
        .clk     (clk),
        .rst     (rst),
        .byte_in (bs.byte_in),
        .accept  (accept),
        .flush   (flush),
        .drop    (drop)
    );

    // New byte lands right after the bits that survive this cycle's consume.
    always_comb begin
        insert    = '0;
        buffer_nx = buffer << consume;
        count_nx  = remain;
        if (accept && !drop) begin
            insert    = BUF_W'(bs.byte_in) << (BUF_W - 8 - int'(remain));
            buffer_nx = buffer_nx | insert;
            count_nx  = remain + bit_count_t'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            buffer     <= '0;
            bit_count  <= '0;
            consumed_q <= '0;
            err_q      <= 1'b0;
        end else begin
            buffer     <= buffer_nx;
            bit_count  <= count_nx;
            consumed_q <= consumed_q + CNT_W'(consume);
            if (!fwd_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign window        = buffer[BUF_W-1 -: 24];
    assign window_valid  = (bit_count >= bit_count_t'(24));
    assign bits_avail    = bit_count;
    assign byte_aligned  = (consumed_q[2:0] == 3'd0);
    assign consumed_bits = consumed_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_bitstream_window.sv
// tb/tb_bitstream_window.sv - scoreboard bench for bitstream_window (EPB on and off instances)
module tb_bitstream_window;

    localparam int BUF_W = 64;

    typedef struct packed {
        logic [23:0] window;
        logic        wvalid;
        logic [6:0]  avail;
        logic        aligned;
        logic [31:0] consumed;
        logic        err;
        logic        ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  fwd = 5'd0;

    logic [23:0] win   [2];
    logic        wval  [2];
    logic [6:0]  avail [2];
    logic        algn  [2];
    logic [31:0] cons  [2];
    logic        uerr  [2];

    bitstream_window_if bif0 ();
    bitstream_window_if bif1 ();

    bitstream_window #(.BUF_W(BUF_W), .EPB_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bs(bif0), .flush(flush), .forward_len(fwd),
        .window(win[0]), .window_valid(wval[0]), .bits_avail(avail[0]),
        .byte_aligned(algn[0]), .consumed_bits(cons[0]), .err_underflow(uerr[0])
    );

    bitstream_window #(.BUF_W(BUF_W), .EPB_EN(1'b0), .CNT_W(32)) dut_raw (
        .clk(clk), .rst(rst), .bs(bif1), .flush(flush), .forward_len(fwd),
        .window(win[1]), .window_valid(wval[1]), .bits_avail(avail[1]),
        .byte_aligned(algn[1]), .consumed_bits(cons[1]), .err_underflow(uerr[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model: the buffered stream as an ordered list of bits.
    logic        mb   [2][0:127];
    int          mcnt [2];
    int          mzr  [2];
    logic [31:0] mcons[2];
    logic        merr [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        mcnt[k]  = 0;
        mzr[k]   = 0;
        mcons[k] = '0;
        merr[k]  = 1'b0;
        for (int i = 0; i < 128; i++) mb[k][i] = 1'b0;
    endtask

    function automatic exp_t snapshot(input int k, input logic fl, input logic r);
        exp_t e;
        for (int i = 0; i < 24; i++) e.window[23-i] = (i < mcnt[k]) ? mb[k][i] : 1'b0;
        e.wvalid   = (mcnt[k] >= 24);
        e.avail    = 7'(mcnt[k]);
        e.aligned  = (mcons[k] % 8 == 0);
        e.consumed = mcons[k];
        e.err      = merr[k];
        e.ready    = !r && !fl && (mcnt[k] <= BUF_W - 16);
        return e;
    endfunction

    task automatic model_update(input int k, input logic [7:0] b, input logic v,
                                input logic fl, input logic [4:0] f, input logic r);
        int  c;
        bit  rdy;
        if (r || fl) begin
            model_reset(k);
        end else begin
            rdy = (mcnt[k] <= BUF_W - 16);
            if (f <= mcnt[k] && f <= 24) c = f;
            else begin
                c = 0;
                merr[k] = 1'b1;
            end
            for (int i = 0; i + c < mcnt[k]; i++) mb[k][i] = mb[k][i+c];
            for (int i = mcnt[k] - c; i < mcnt[k]; i++) mb[k][i] = 1'b0;
            mcnt[k]  = mcnt[k] - c;
            mcons[k] = mcons[k] + 32'(c);
            if (v && rdy) begin
                if (k == 0 && mzr[k] == 2 && b == 8'h03) begin
                    mzr[k] = 0;
                end else begin
                    for (int j = 7; j >= 0; j--) begin
                        mb[k][mcnt[k]] = b[j];
                        mcnt[k]++;
                    end
                    mzr[k] = (b == 8'h00) ? ((mzr[k] < 2) ? mzr[k] + 1 : 2) : 0;
                end
            end
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v, input logic fl,
                        input logic [4:0] f, input logic r);
        @(posedge clk);
        #1;
        bif0.byte_in = b; bif0.byte_valid = v;
        bif1.byte_in = b; bif1.byte_valid = v;
        flush = fl; fwd = f; rst = r;
        sb0.push_back(snapshot(0, fl, r));
        sb1.push_back(snapshot(1, fl, r));
        model_update(0, b, v, fl, f, r);
        model_update(1, b, v, fl, f, r);
    endtask

    task automatic idle_peek();
        step(8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
    endtask

    task automatic cmp(input int k, input exp_t e);
        logic rdy;
        rdy = (k == 0) ? bif0.byte_ready : bif1.byte_ready;
        chk($sformatf("d%0d window", k),    32'(win[k]),   32'(e.window));
        chk($sformatf("d%0d win_valid", k), 32'(wval[k]),  32'(e.wvalid));
        chk($sformatf("d%0d bits_avail", k),32'(avail[k]), 32'(e.avail));
        chk($sformatf("d%0d aligned", k),   32'(algn[k]),  32'(e.aligned));
        chk($sformatf("d%0d consumed", k),  cons[k],       e.consumed);
        chk($sformatf("d%0d underflow", k), 32'(uerr[k]),  32'(e.err));
        chk($sformatf("d%0d byte_ready", k),32'(rdy),      32'(e.ready));
    endtask

    always @(negedge clk) begin
        if (sb0.size() > 0 && sb1.size() > 0) begin
            cmp(0, sb0.pop_front());
            cmp(1, sb1.pop_front());
        end
    end

    initial begin
        logic [7:0] b;
        logic [4:0] f;
        int         r;

        bif0.byte_in = 8'h00; bif0.byte_valid = 1'b0;
        bif1.byte_in = 8'h00; bif1.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        // basic fill and window
        step(8'hA5, 1, 0, 0, 1'b0);
        step(8'h3C, 1, 0, 0, 1'b0);
        step(8'h0F, 1, 0, 0, 1'b0);
        step(8'h00, 1, 0, 0, 1'b0);
        idle_peek();
        chk("fill window", 32'(win[0]), 32'h00A53C0F);
        chk("fill valid", 32'(wval[0]), 32'd1);
        chk("fill avail", 32'(avail[0]), 32'd32);
        chk("fill ready", 32'(bif0.byte_ready), 32'd1);

        step(8'h00, 0, 0, 5'd3, 1'b0);
        idle_peek();
        chk("fwd3 window", 32'(win[0]), 32'h0029E078);
        chk("fwd3 consumed", cons[0], 32'd3);
        chk("fwd3 aligned", 32'(algn[0]), 32'd0);
        step(8'h00, 0, 0, 5'd5, 1'b0);
        idle_peek();
        chk("fwd5 window", 32'(win[0]), 32'h003C0F00);
        chk("fwd5 aligned", 32'(algn[0]), 32'd1);

        // illegal length, then flush with a byte offered
        step(8'h00, 0, 0, 5'd31, 1'b0);
        step(8'h55, 1, 1, 5'd0, 1'b0);
        idle_peek();
        chk("flush avail", 32'(avail[0]), 32'd0);
        chk("flush consumed", cons[0], 32'd0);
        chk("flush err", 32'(uerr[0]), 32'd0);

        // emulation prevention on and off
        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h03, 1, 0, 0, 1'b0);
        step(8'h01, 1, 0, 0, 1'b0);
        idle_peek();
        chk("epb avail", 32'(avail[0]), 32'd24);
        chk("epb window", 32'(win[0]), 32'h00000001);
        chk("raw avail", 32'(avail[1]), 32'd32);
        chk("raw window", 32'(win[1]), 32'h00000003);
        step(8'h00, 0, 1, 0, 1'b0);

        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h03, 1, 0, 0, 1'b0);
        step(8'h03, 1, 0, 0, 1'b0);
        idle_peek();
        chk("epb 0303 avail", 32'(avail[0]), 32'd24);
        chk("epb 0303 window", 32'(win[0]), 32'h00000003);
        step(8'h00, 0, 1, 0, 1'b0);

        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h00, 0, 1, 0, 1'b0);
        step(8'h00, 1, 0, 0, 1'b0);
        step(8'h03, 1, 0, 0, 1'b0);
        idle_peek();
        chk("epb flush avail", 32'(avail[0]), 32'd16);
        chk("epb flush window", 32'(win[0]), 32'h00000300);
        step(8'h00, 0, 1, 0, 1'b0);

        // back-pressure at the top of the buffer
        for (int i = 0; i < 8; i++) step(8'hAA, 1, 0, 0, 1'b0);
        idle_peek();
        chk("full avail", 32'(avail[0]), 32'd56);
        chk("full ready", 32'(bif0.byte_ready), 32'd0);
        step(8'hAA, 1, 0, 5'd24, 1'b0);
        step(8'hAA, 1, 0, 5'd0, 1'b0);
        idle_peek();
        chk("drain avail", 32'(avail[0]), 32'd40);
        step(8'h00, 0, 1, 0, 1'b0);

        // underflow handling
        step(8'h5A, 1, 0, 0, 1'b0);
        idle_peek();
        chk("uf pre avail", 32'(avail[0]), 32'd8);
        step(8'h00, 0, 0, 5'd9, 1'b0);
        idle_peek();
        chk("uf err", 32'(uerr[0]), 32'd1);
        chk("uf avail", 32'(avail[0]), 32'd8);
        step(8'h00, 0, 0, 5'd8, 1'b0);
        step(8'h00, 0, 0, 5'd4, 1'b0);
        idle_peek();
        chk("tail avail", 32'(avail[0]), 32'd0);
        chk("tail consumed", cons[0], 32'd8);

        // reset during an accept
        step(8'h77, 1, 0, 0, 1'b1);
        idle_peek();
        chk("rst window", 32'(win[0]), 32'd0);
        chk("rst avail", 32'(avail[0]), 32'd0);
        chk("rst aligned", 32'(algn[0]), 32'd1);
        chk("rst err", 32'(uerr[0]), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 3);
            b = (r == 1) ? 8'h03 : (r == 3) ? 8'($urandom) : 8'h00;
            f = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 12));
            step(b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0), f,
                 ($urandom_range(0, 255) == 0));
        end
        step(8'h00, 0, 0, 0, 1'b0);

        for (int t = 0; t < 10 && (sb0.size() > 0 || sb1.size() > 0); t++) @(negedge clk);
        checks++;
        if (sb0.size() > 0 || sb1.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb0.size() + sb1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
